// File: rtl/cache_controller_pkg.sv
// Shared geometry, address-field positions and FSM encoding for the two-way read cache.
package cache_controller_pkg;

  localparam logic [31:0] BASE_ADDR = 32'd1024;
  localparam int          SETS      = 64;
  localparam int          TAG_W     = 10;
  localparam int          IDX_W     = 6;
  localparam int          WSEL_BIT  = 2;
  localparam int          IDX_LSB   = 3;
  localparam int          TAG_LSB   = IDX_LSB + IDX_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic             wsel;
  } addr_fields_t;

  // Geometry is taken on the offset from the data-memory base, not the raw address.
  function automatic addr_fields_t split_addr(input logic [31:0] addr);
    logic [31:0] a;
    a = addr - BASE_ADDR;
    split_addr.tag  = a[TAG_LSB +: TAG_W];
    split_addr.idx  = a[IDX_LSB +: IDX_W];
    split_addr.wsel = a[WSEL_BIT];
  endfunction

endpackage

// File: rtl/cache_set_array.sv
// Valid/tag/data/LRU storage for the two-way cache; combinational read, synchronous writes.
module cache_set_array
  import cache_controller_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] idx_i,
  output logic [1:0]       valid_o,
  output logic [TAG_W-1:0] tag0_o,
  output logic [TAG_W-1:0] tag1_o,
  output logic [63:0]      data0_o,
  output logic [63:0]      data1_o,
  output logic             lru_o,
  input  logic             fill_en_i,
  input  logic             fill_way_i,
  input  logic [TAG_W-1:0] fill_tag_i,
  input  logic [63:0]      fill_data_i,
  input  logic             upd_en_i,
  input  logic             upd_way_i,
  input  logic             upd_wsel_i,
  input  logic [31:0]      upd_word_i,
  input  logic             lru_en_i,
  input  logic             lru_val_i
);

  logic [SETS-1:0]  valid0_q;
  logic [SETS-1:0]  valid1_q;
  logic [SETS-1:0]  lru_q;
  logic [TAG_W-1:0] tag_q  [2][SETS];
  logic [63:0]      data_q [2][SETS];

  assign valid_o = {valid1_q[idx_i], valid0_q[idx_i]};
  assign tag0_o  = tag_q[0][idx_i];
  assign tag1_o  = tag_q[1][idx_i];
  assign data0_o = data_q[0][idx_i];
  assign data1_o = data_q[1][idx_i];
  assign lru_o   = lru_q[idx_i];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid0_q <= '0;
      valid1_q <= '0;
      lru_q    <= '0;
    end else begin
      if (fill_en_i && !fill_way_i) valid0_q[idx_i] <= 1'b1;
      if (fill_en_i &&  fill_way_i) valid1_q[idx_i] <= 1'b1;
      if (lru_en_i)                 lru_q[idx_i]    <= lru_val_i;
    end
  end

  // Tag and data need no reset: nothing is read from a way until its valid bit is set.
  always_ff @(posedge clk) begin
    if (fill_en_i) begin
      tag_q[fill_way_i][idx_i]  <= fill_tag_i;
      data_q[fill_way_i][idx_i] <= fill_data_i;
    end else if (upd_en_i) begin
      data_q[upd_way_i][idx_i][{upd_wsel_i, 5'd0} +: 32] <= upd_word_i;
    end
  end

endmodule

// File: rtl/cache_controller.sv
// Two-way set-associative read cache between the MEM stage and the SRAM controller (write-through).
module cache_controller
  import cache_controller_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        sram_rd_en,
  output logic        sram_wr_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  input  logic [63:0] sram_rdata,
  input  logic        sram_ready
);

  state_e       state_q, state_d;
  addr_fields_t fld;
  logic [1:0]       valid;
  logic [TAG_W-1:0] tag0, tag1;
  logic [63:0]      data0, data1, hit_data;
  logic             lru, hit0, hit1, hit, hit_way, victim;
  logic             fill_en, upd_en, lru_en, lru_val;
  logic [31:0]      blk_addr;

  assign fld      = split_addr(address);
  assign blk_addr = {address[31:3], 1'b0, address[1:0]};
  assign hit0     = valid[0] && (tag0 == fld.tag);
  assign hit1     = valid[1] && (tag1 == fld.tag);
  assign hit      = hit0 || hit1;
  assign hit_way  = hit1;
  assign hit_data = hit1 ? data1 : data0;
  assign victim   = !valid[0] ? 1'b0 : (!valid[1] ? 1'b1 : lru);

  cache_set_array u_array (
    .clk         (clk),
    .rst         (rst),
    .idx_i       (fld.idx),
    .valid_o     (valid),
    .tag0_o      (tag0),
    .tag1_o      (tag1),
    .data0_o     (data0),
    .data1_o     (data1),
    .lru_o       (lru),
    .fill_en_i   (fill_en),
    .fill_way_i  (victim),
    .fill_tag_i  (fld.tag),
    .fill_data_i (sram_rdata),
    .upd_en_i    (upd_en),
    .upd_way_i   (hit_way),
    .upd_wsel_i  (fld.wsel),
    .upd_word_i  (wdata),
    .lru_en_i    (lru_en),
    .lru_val_i   (lru_val)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Outputs are forced to their idle values while rst is high so an aborted fetch drops at once.
  always_comb begin
    state_d      = state_q;
    ready        = 1'b1;
    rdata        = '0;
    sram_rd_en   = 1'b0;
    sram_wr_en   = 1'b0;
    sram_address = '0;
    sram_wdata   = '0;
    fill_en      = 1'b0;
    upd_en       = 1'b0;
    lru_en       = 1'b0;
    lru_val      = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (wr_en) begin
            sram_wr_en   = 1'b1;
            sram_address = address;
            sram_wdata   = wdata;
            ready        = 1'b0;
            state_d      = WR_WAIT;
            if (hit) begin
              upd_en  = 1'b1;
              lru_en  = 1'b1;
              lru_val = ~hit_way;
            end
          end else if (rd_en) begin
            if (hit) begin
              rdata   = fld.wsel ? hit_data[63:32] : hit_data[31:0];
              lru_en  = 1'b1;
              lru_val = ~hit_way;
            end else begin
              sram_rd_en   = 1'b1;
              sram_address = blk_addr;
              ready        = 1'b0;
              state_d      = RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          sram_rd_en   = 1'b1;
          sram_address = blk_addr;
          ready        = 1'b0;
          if (sram_ready) begin
            fill_en = 1'b1;
            lru_en  = 1'b1;
            lru_val = ~victim;
            rdata   = fld.wsel ? sram_rdata[63:32] : sram_rdata[31:0];
            ready   = 1'b1;
            state_d = IDLE;
          end
        end
        WR_WAIT: begin
          sram_wr_en   = 1'b1;
          sram_address = address;
          sram_wdata   = wdata;
          ready        = 1'b0;
          if (sram_ready) begin
            ready   = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
